// File: rtl/data_ram_responder_pkg.sv
// Shared constants and state encoding for the data RAM responder.
package data_ram_responder_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;

    localparam logic ZERO          = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        RAM_IDLE = 2'd0,
        RAM_WAIT = 2'd1,
        RAM_RESP = 2'd2
    } ram_state_e;

    // WAIT is skipped entirely when the latency is a single cycle.
    function automatic logic [3:0] wait_count_init(input int unsigned latency);
        if (latency > 1) begin
            return 4'(latency - 2);
        end
        return '0;
    endfunction

endpackage

// File: rtl/sp_ram_array.sv
// Synchronous single-port word array with registered read data.
module sp_ram_array #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_WIDTH   = $clog2(DEPTH_WORDS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [IDX_WIDTH-1:0]  i_idx,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_ram_responder.sv
// Word-addressed data RAM responder: one full-word access at a time with a
// fixed, configurable latency and a one-cycle completion pulse.
module data_ram_responder #(
    parameter int unsigned ADDR_WIDTH  = data_ram_responder_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = data_ram_responder_pkg::DATA_WIDTH,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ram_req_i,
    input  logic [ADDR_WIDTH-1:0] ram_addr_i,
    input  logic                  ram_w_request_i,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    output logic                  data_ready_o,
    output logic                  busy_o,
    output logic                  err_o
);

    import data_ram_responder_pkg::*;

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = wait_count_init(LATENCY);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("data_ram_responder: LATENCY must be in 1..15");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("data_ram_responder: DEPTH_WORDS must be a power of two");
    end
    if (ADDR_WIDTH < IDX_W + 2) begin : g_bad_addr
        $error("data_ram_responder: ADDR_WIDTH too small for DEPTH_WORDS");
    end

    ram_state_e            r_state;
    logic [3:0]            r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_wr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_oor;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_err;
    logic                  r_rd_oor;

    logic [IDX_W-1:0]      w_in_idx;
    logic                  w_in_oor;
    logic                  w_idle;
    logic                  w_enter_resp;
    logic [IDX_W-1:0]      w_cur_idx;
    logic                  w_cur_wr;
    logic [DATA_WIDTH-1:0] w_cur_wdata;
    logic                  w_cur_oor;
    logic                  w_we;
    logic                  w_re;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused;

    assign w_in_idx = ram_addr_i[IDX_W+1:2];
    assign w_unused = &{1'b0, ram_addr_i[1:0]};

    if (ADDR_WIDTH > IDX_W + 2) begin : g_oor
        assign w_in_oor = |ram_addr_i[ADDR_WIDTH-1:IDX_W+2];
    end else begin : g_no_oor
        assign w_in_oor = ZERO;
    end

    // With LATENCY=1 the array is accessed on the acceptance edge itself,
    // so the live inputs stand in for the not-yet-latched copies.
    assign w_idle       = (r_state == RAM_IDLE);
    assign w_enter_resp = (w_idle && ram_req_i && LATENCY == 1)
                       || (r_state == RAM_WAIT && r_cnt == '0);
    assign w_cur_idx    = w_idle ? w_in_idx        : r_idx;
    assign w_cur_wr     = w_idle ? ram_w_request_i : r_wr;
    assign w_cur_wdata  = w_idle ? ram_data_i      : r_wdata;
    assign w_cur_oor    = w_idle ? w_in_oor        : r_oor;

    assign w_we = rst_ni && w_enter_resp && (w_cur_wr == WRITE_ENABLE) && !w_cur_oor;
    assign w_re = w_enter_resp && (w_cur_wr == WRITE_DISABLE) && !w_cur_oor;

    sp_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_WIDTH  (IDX_W)
    ) u_array (
        .i_clk  (clk_i),
        .i_rst_n(rst_ni),
        .i_we   (w_we),
        .i_re   (w_re),
        .i_idx  (w_cur_idx),
        .i_wdata(w_cur_wdata),
        .o_rdata(w_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= RAM_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_wr     <= 1'b0;
            r_wdata  <= '0;
            r_oor    <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_rd_oor <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            unique case (r_state)
                RAM_IDLE: begin
                    if (ram_req_i) begin
                        r_idx   <= w_in_idx;
                        r_wr    <= ram_w_request_i;
                        r_wdata <= ram_data_i;
                        r_oor   <= w_in_oor;
                        r_busy  <= 1'b1;
                        if (LATENCY == 1) begin
                            r_state <= RAM_RESP;
                        end else begin
                            r_state <= RAM_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                RAM_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= RAM_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RAM_RESP: begin
                    r_state <= RAM_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= RAM_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            if (w_enter_resp) begin
                r_ready <= 1'b1;
                r_err   <= w_cur_oor;
                if (w_cur_wr == WRITE_DISABLE) begin
                    r_rd_oor <= w_cur_oor;
                end
            end
        end
    end

    assign ram_data_o   = r_rd_oor ? '0 : w_rdata;
    assign data_ready_o = r_ready;
    assign busy_o       = r_busy;
    assign err_o        = r_err;

endmodule

// File: tb/tb_data_ram_responder.sv
// Randomized bench for data_ram_responder at LATENCY 2, 3 and 1 against a
// word-level reference memory.
module tb_data_ram_responder;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        ready [3];
    logic        busy  [3];
    logic        err   [3];

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem_model [int];
    logic [31:0] last_rd    [3];
    bit          last_known [3];

    always #5 clk = ~clk;

    data_ram_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(2)) u_dut_l2 (
        .clk_i(clk), .rst_ni(rst_n), .ram_req_i(req[0]), .ram_addr_i(addr[0]),
        .ram_w_request_i(we[0]), .ram_data_i(wdata[0]), .ram_data_o(rdata[0]),
        .data_ready_o(ready[0]), .busy_o(busy[0]), .err_o(err[0]));

    data_ram_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(3)) u_dut_l3 (
        .clk_i(clk), .rst_ni(rst_n), .ram_req_i(req[1]), .ram_addr_i(addr[1]),
        .ram_w_request_i(we[1]), .ram_data_i(wdata[1]), .ram_data_o(rdata[1]),
        .data_ready_o(ready[1]), .busy_o(busy[1]), .err_o(err[1]));

    data_ram_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(1)) u_dut_l1 (
        .clk_i(clk), .rst_ni(rst_n), .ram_req_i(req[2]), .ram_addr_i(addr[2]),
        .ram_w_request_i(we[2]), .ram_data_i(wdata[2]), .ram_data_o(rdata[2]),
        .data_ready_o(ready[2]), .busy_o(busy[2]), .err_o(err[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : (s == 1) ? 3 : 1;
    endfunction

    function automatic int key_of(input int s, input logic [31:0] a);
        return s * int'(DEPTH) + int'(a / 4);
    endfunction

    task automatic idle_cycle(input int s);
        @(posedge clk); #1;
        chk($sformatf("idle%0d.ready", s), 32'(ready[s]), 0);
        chk($sformatf("idle%0d.busy", s), 32'(busy[s]), 0);
        chk($sformatf("idle%0d.err", s), 32'(err[s]), 0);
    endtask

    // Called one time unit after a rising edge, with instance s idle.
    task automatic access(input int s, input bit wr, input logic [31:0] a, input logic [31:0] d);
        int          lat;
        bit          inr;
        bit          exp_known;
        logic [31:0] exp_rd;
        string       t;
        lat       = lat_of(s);
        inr       = (a < DEPTH * 4);
        t         = $sformatf("L%0d.%s@%h", lat, wr ? "wr" : "rd", a);
        exp_rd    = '0;
        exp_known = 1'b1;
        if (!wr && inr) begin
            if (mem_model.exists(key_of(s, a))) exp_rd = mem_model[key_of(s, a)];
            else exp_known = 1'b0;
        end
        chk({t, ".pre_busy"}, 32'(busy[s]), 0);
        req[s] = 1'b1; we[s] = wr; addr[s] = a; wdata[s] = d;
        for (int j = 1; j <= lat; j++) begin
            @(posedge clk); #1;
            if (j == 1) begin
                addr[s]  = $urandom;
                wdata[s] = $urandom;
                we[s]    = ~wr;
            end
            chk($sformatf("%s.busy%0d", t, j), 32'(busy[s]), 1);
            chk($sformatf("%s.ready%0d", t, j), 32'(ready[s]), (j == lat) ? 1 : 0);
            if (j == lat) begin
                chk({t, ".err"}, 32'(err[s]), inr ? 0 : 1);
                if (!wr) begin
                    if (exp_known) chk({t, ".data"}, rdata[s], exp_rd);
                    last_rd[s]    = exp_rd;
                    last_known[s] = exp_known;
                end else if (last_known[s]) begin
                    chk({t, ".hold"}, rdata[s], last_rd[s]);
                end
                req[s] = 1'b0;
            end
        end
        if (wr && inr) mem_model[key_of(s, a)] = d;
        @(posedge clk); #1;
        chk({t, ".post_busy"}, 32'(busy[s]), 0);
        chk({t, ".post_ready"}, 32'(ready[s]), 0);
        chk({t, ".post_err"}, 32'(err[s]), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pres [12];
        int          pulses;
        bit          exp_pulse;
        logic [31:0] a;

        for (int s = 0; s < 3; s++) begin
            req[s] = 1'b0; we[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
            last_rd[s] = '0; last_known[s] = 1'b1;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst%0d.data", s), rdata[s], 0);
            chk($sformatf("rst%0d.ready", s), 32'(ready[s]), 0);
            chk($sformatf("rst%0d.busy", s), 32'(busy[s]), 0);
            chk($sformatf("rst%0d.err", s), 32'(err[s]), 0);
        end
        rst_n = 1'b1;
        idle_cycle(0);

        // Directed sequence at LATENCY=2
        access(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        access(0, 1'b0, 32'h0000_0010, 32'h0);
        access(0, 1'b0, 32'h0000_0013, 32'h0);
        access(0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D);
        access(0, 1'b1, 32'h0001_0000, 32'h1111_1111);
        access(0, 1'b0, 32'h0000_0000, 32'h0);
        access(0, 1'b0, 32'h0001_0000, 32'h0);
        access(0, 1'b0, 32'h0000_0010, 32'h0);
        access(0, 1'b0, 32'hFFFF_FFFC, 32'h0);

        // Held request at LATENCY=3 with the address wandering every cycle
        for (int w = 0; w < 16; w++) access(1, 1'b1, 32'(w * 4), $urandom);
        pulses  = 0;
        pres[0] = $urandom_range(0, 63);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = pres[0];
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            exp_pulse = (c == 3 || c == 7 || c == 11);
            chk($sformatf("held.ready%0d", c), 32'(ready[1]), exp_pulse ? 1 : 0);
            chk($sformatf("held.busy%0d", c), 32'(busy[1]), (c % 4 != 0) ? 1 : 0);
            if (ready[1] === 1'b1) pulses++;
            if (exp_pulse) begin
                chk($sformatf("held.data%0d", c), rdata[1], mem_model[key_of(1, pres[c-3])]);
                last_rd[1] = mem_model[key_of(1, pres[c-3])];
            end
            if (c <= 11) begin
                pres[c] = $urandom_range(0, 63);
                addr[1] = pres[c];
            end
            if (c == 11) req[1] = 1'b0;
        end
        chk("held.pulses", 32'(pulses), 3);

        // Reset while a write sits in WAIT
        access(0, 1'b1, 32'h0000_0020, 32'h1234_5678);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        chk("midrst.busy_before", 32'(busy[0]), 1);
        rst_n  = 1'b0;
        req[0] = 1'b0;
        #1;
        chk("midrst.busy", 32'(busy[0]), 0);
        chk("midrst.ready", 32'(ready[0]), 0);
        @(posedge clk); #1;
        chk("midrst.ready_next", 32'(ready[0]), 0);
        chk("midrst.data", rdata[0], 0);
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            last_rd[s] = '0; last_known[s] = 1'b1;
        end
        idle_cycle(0);
        access(0, 1'b0, 32'h0000_0020, 32'h0);

        // LATENCY=1 round trip
        access(2, 1'b1, 32'h0000_0040, 32'hA5A5_5A5A);
        access(2, 1'b0, 32'h0000_0040, 32'h0);
        access(2, 1'b0, 32'h0000_2000, 32'h0);

        // Randomized traffic on every instance
        for (int s = 0; s < 3; s++) begin
            for (int n = 0; n < 40; n++) begin
                if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_1000;
                else a = $urandom_range(0, 255);
                access(s, 1'($urandom_range(0, 1)), a, $urandom);
                repeat ($urandom_range(0, 2)) idle_cycle(s);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_ram_responder.md
# data_ram_responder

Word-addressed data RAM that serves the memory-stage load/store port. It is the responder end of the `ram_addr`/`ram_w_request`/`ram_data` interface.
- Accepts one full-word access at a time.
- Models a configurable access latency.
- Returns read data with a one-cycle `data_ready_o` pulse.
- Byte/halfword merging stays in the memory stage; this block only reads and writes whole words.

## Interface
- `ADDR_WIDTH`, default 32: byte address width.
- `DATA_WIDTH`, default 32: word width.
- `DEPTH_WORDS`, default 1024: number of words, must be a power of two.
- `LATENCY`, default 2: cycles from request presented to `data_ready_o`, legal range 1..15.

Ports:
- `clk_i` in 1: single clock; all state on rising edge.
- `rst_ni` in 1: reset, asynchronous assert, active-low.
- `ram_req_i` in 1: access request, level, held by initiator until `data_ready_o`.
- `ram_addr_i` in `ADDR_WIDTH`: byte address; bits [1:0] ignored.
- `ram_w_request_i` in 1: 1 = write, 0 = read.
- `ram_data_i` in `DATA_WIDTH`: write word, already merged by the initiator.
- `ram_data_o` out `DATA_WIDTH`: read word; held until the next read completes.
- `data_ready_o` out 1: one-cycle completion pulse for read or write.
- `busy_o` out 1: access in flight (state ≠ IDLE).
- `err_o` out 1: one-cycle pulse coincident with `data_ready_o` when the address is out of range.

## Operation
- Word index = `ram_addr_i[log2(DEPTH_WORDS)+1:2]`. The address is out of range when any bit above that index is nonzero.
- States:
  - IDLE → (`ram_req_i`=1) → WAIT when `LATENCY`>1, or directly to RESP when `LATENCY`=1.
  - WAIT counts down; at count 0 → RESP.
  - RESP → IDLE unconditionally.
- Acceptance happens only in IDLE. Address, direction and write data are latched at acceptance. Input changes after acceptance have no effect on the in-flight access.
- Write: the latched word is stored on the edge entering RESP. Out-of-range writes are dropped.
- Read: the word is registered into `ram_data_o` on the edge entering RESP. Out-of-range reads return 0.
- `ram_data_o` is unchanged by write completions.
- Read-after-write to the same word returns the new data. Only one access is ever outstanding, so no bypass logic exists.
- The initiator must drop `ram_req_i`, or present the next request, in the cycle after RESP. A `ram_req_i` still high in the IDLE cycle following RESP is accepted as a new access.
- RAM contents are not cleared by reset and are X until written.

## Timing
- Reset values: `ram_data_o`=0, `data_ready_o`=0, `busy_o`=0, `err_o`=0, state IDLE, counter 0.
- Request present in cycle N (IDLE): `data_ready_o`=1 in cycle N+`LATENCY`. `busy_o`=1 in cycles N+1 .. N+`LATENCY`.
- Throughput: one access per `LATENCY`+1 cycles with a continuously held request.
- The WAIT counter loads `LATENCY`-2 at acceptance. It is 4 bits wide and never wraps, because `LATENCY` ≤ 15 is enforced by an elaboration-time check.
- Reset mid-access: the state returns to IDLE immediately, the pending write is not committed, and no `data_ready_o` is produced.
- `ram_req_i`=0 in IDLE: no state change, and outputs other than `ram_data_o` stay 0.

## Structure
- `defines.v` holds the shared constants `ZERO`, `WRITE_ENABLE`/`WRITE_DISABLE` and `ADDR_WIDTH`/`DATA_WIDTH`. This block adds `RAM_IDLE`/`RAM_WAIT`/`RAM_RESP` state encodings (2 bits) there.
- One sub-module, `sp_ram_array`, holds the synchronous single-port word array: write enable, word index, write data, and registered read data. The responder instantiates it and owns the FSM, counter, latching and error logic.

## Test plan
- Reset, then write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 (`LATENCY`=2) → `data_ready_o` pulses 2 cycles after each request; the read returns 0xDEADBEEF with `err_o`=0.
- Read 0x0000_0013 after the test above → returns 0xDEADBEEF, since the low address bits are ignored.
- Write 0x11111111 to 0x0001_0000 with `DEPTH_WORDS`=1024 → `err_o`=1 with `data_ready_o`. A subsequent read of 0x0000_0000 is unaffected. An out-of-range read returns 0 and pulses `err_o`.
- Hold `ram_req_i`=1 for 12 cycles with `LATENCY`=3 → exactly 3 `data_ready_o` pulses at cycles 3, 7 and 11. The change of `ram_addr_i` mid-access is ignored.
- Assert `rst_ni`=0 in WAIT of a write of 0xCAFEF00D to 0x20 → no `data_ready_o`, `busy_o`=0 immediately, and a later read of 0x20 returns the prior value.
- `LATENCY`=1: read request in cycle N → `data_ready_o`=1 in cycle N+1, `busy_o`=1 only in N+1.
